// File: rtl/adpll_mod_src_if.sv
// Configuration and output bundle of the ADPLL modulation-data source.
// The master side programs the source; the slave side is the source itself.
interface adpll_mod_src_if #(
    parameter int TICK_W = 16,
    parameter int PAT_W  = 32,
    parameter int PRE_W  = 8,
    parameter int LFSR_W = 9,
    parameter int CNT_W  = 16
);
    logic              en;
    logic [1:0]        mode;
    logic [TICK_W-1:0] sym_period;
    logic [PRE_W-1:0]  pre_len;
    logic [PAT_W-1:0]  pattern;
    logic [LFSR_W-1:0] seed;
    logic              data_mod;
    logic              sym_strobe;
    logic              busy;
    logic [CNT_W-1:0]  sym_count;

    modport master (
        output en, mode, sym_period, pre_len, pattern, seed,
        input  data_mod, sym_strobe, busy, sym_count
    );

    modport slave (
        input  en, mode, sym_period, pre_len, pattern, seed,
        output data_mod, sym_strobe, busy, sym_count
    );
endinterface

// File: rtl/adpll_mod_src.sv
// Modulation-data source for the ADPLL TX path: alternating preamble followed by
// a zeros / alternating / PRBS / pattern payload, one bit per programmable symbol period.
module adpll_mod_src #(
    parameter int                TICK_W    = 16,
    parameter int                PAT_W     = 32,
    parameter int                PRE_W     = 8,
    parameter int                LFSR_W    = 9,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 9'h110,
    parameter int                CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    adpll_mod_src_if.slave bus
);
    localparam int PIDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [PIDX_W-1:0] PAT_LAST  = PIDX_W'(PAT_W - 1);
    localparam logic [LFSR_W-1:0] LFSR_ONES = {LFSR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [TICK_W-1:0]   r_tick, w_tick_nxt;
    logic [PRE_W-1:0]    r_pre_cnt, w_pre_cnt_nxt;
    logic [PIDX_W-1:0]   r_pat_idx, w_pat_idx_nxt;
    logic                r_alt, w_alt_nxt;
    logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nxt;
    logic                r_data, w_data_nxt;
    logic                r_strobe, w_strobe_nxt;
    logic                r_busy, w_busy_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                w_boundary;
    logic                w_pre_last;
    logic                w_fb;

    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

    // '>=' rather than '==' so shrinking sym_period mid-symbol cannot skip the boundary
    assign w_boundary = (r_tick >= bus.sym_period);
    assign w_pre_last = (({1'b0, r_pre_cnt} + (PRE_W + 1)'(1)) >= {1'b0, bus.pre_len});
    assign w_fb       = lfsr_feedback(r_lfsr);

    // Next-state and datapath update for the IDLE / PREAMBLE / RUN sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick;
        w_pre_cnt_nxt = r_pre_cnt;
        w_pat_idx_nxt = r_pat_idx;
        w_alt_nxt     = r_alt;
        w_lfsr_nxt    = r_lfsr;
        w_data_nxt    = r_data;
        w_strobe_nxt  = 1'b0;
        w_busy_nxt    = r_busy;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_data_nxt = 1'b0;
                if (bus.en) begin
                    w_tick_nxt    = '0;
                    w_pre_cnt_nxt = '0;
                    w_pat_idx_nxt = '0;
                    w_alt_nxt     = 1'b0;
                    w_lfsr_nxt    = (bus.seed == '0) ? LFSR_ONES : bus.seed;
                    w_cnt_nxt     = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = (bus.pre_len != '0) ? ST_PRE : ST_RUN;
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            ST_PRE, ST_RUN: begin
                if (!bus.en) begin
                    w_state_nxt = ST_IDLE;
                    w_data_nxt  = 1'b0;
                    w_tick_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end else if (w_boundary) begin
                    w_tick_nxt   = '0;
                    w_strobe_nxt = 1'b1;
                    if (r_state == ST_PRE) begin
                        w_data_nxt    = ~r_alt;
                        w_alt_nxt     = ~r_alt;
                        w_pre_cnt_nxt = r_pre_cnt + PRE_W'(1);
                        w_state_nxt   = w_pre_last ? ST_RUN : ST_PRE;
                    end else begin
                        w_cnt_nxt = (r_cnt != CNT_MAX) ? (r_cnt + CNT_W'(1)) : r_cnt;
                        case (bus.mode)
                            2'd0: w_data_nxt = 1'b0;
                            2'd1: begin
                                w_data_nxt = ~r_alt;
                                w_alt_nxt  = ~r_alt;
                            end
                            2'd2: begin
                                w_data_nxt = w_fb;
                                w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], w_fb};
                            end
                            2'd3: begin
                                w_data_nxt    = bus.pattern[r_pat_idx];
                                w_pat_idx_nxt = (r_pat_idx == PAT_LAST) ? '0 : (r_pat_idx + PIDX_W'(1));
                            end
                            default: w_data_nxt = 1'b0;
                        endcase
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_data_nxt  = 1'b0;
                w_tick_nxt  = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; all outputs come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tick    <= '0;
            r_pre_cnt <= '0;
            r_pat_idx <= '0;
            r_alt     <= 1'b0;
            r_lfsr    <= LFSR_ONES;
            r_data    <= 1'b0;
            r_strobe  <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_pre_cnt <= w_pre_cnt_nxt;
            r_pat_idx <= w_pat_idx_nxt;
            r_alt     <= w_alt_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_data    <= w_data_nxt;
            r_strobe  <= w_strobe_nxt;
            r_busy    <= w_busy_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.data_mod   = r_data;
    assign bus.sym_strobe = r_strobe;
    assign bus.busy       = r_busy;
    assign bus.sym_count  = r_cnt;
endmodule

// File: tb/tb_adpll_mod_src.sv
// Self-checking bench for adpll_mod_src: vector table driven through a
// scoreboard of expected symbols, plus abort, reset, PRBS period and saturation sequences.
module tb_adpll_mod_src;
    localparam int TICK_W = 16;
    localparam int PAT_W  = 32;
    localparam int PRE_W  = 8;
    localparam int LFSR_W = 9;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [1:0]  mode;
        int          sp;
        int          pre;
        logic [31:0] pattern;
        logic [8:0]  seed;
        int          nbits;
        logic [15:0] exp_bits;
    } vec_t;

    typedef struct {
        logic bit_v;
        int   cnt;
        int   at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adpll_mod_src_if #(.TICK_W(TICK_W), .PAT_W(PAT_W), .PRE_W(PRE_W), .LFSR_W(LFSR_W), .CNT_W(CNT_W)) bus ();
    adpll_mod_src_if #(.TICK_W(TICK_W), .PAT_W(PAT_W), .PRE_W(PRE_W), .LFSR_W(LFSR_W), .CNT_W(4)) bus4 ();

    adpll_mod_src #(.TICK_W(TICK_W), .PAT_W(PAT_W), .PRE_W(PRE_W), .LFSR_W(LFSR_W),
                    .LFSR_TAPS(9'h110), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    adpll_mod_src #(.TICK_W(TICK_W), .PAT_W(PAT_W), .PRE_W(PRE_W), .LFSR_W(LFSR_W),
                    .LFSR_TAPS(9'h110), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input int sp, input int pre,
                                input logic [31:0] pat, input logic [8:0] sd,
                                input int nb, input logic [15:0] eb);
        vec_t v;
        v.mode = m; v.sp = sp; v.pre = pre; v.pattern = pat;
        v.seed = sd; v.nbits = nb; v.exp_bits = eb;
        return v;
    endfunction

    // Program a run, raise en and queue the expected symbols with their strobe cycles
    task automatic start_run(input vec_t v, input bit wait_neg, output int start);
        if (wait_neg) @(negedge clk);
        bus.mode       = v.mode;
        bus.sym_period = 16'(v.sp);
        bus.pre_len    = 8'(v.pre);
        bus.pattern    = v.pattern;
        bus.seed       = v.seed;
        bus.en         = 1'b1;
        start = cyc + 1;
        for (int i = 0; i < v.nbits; i++) begin
            exp_t e;
            e.bit_v = v.exp_bits[i];
            e.cnt   = (i < v.pre) ? 0 : (i - v.pre + 1);
            e.at    = start + (i + 1) * (v.sp + 1);
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sbq.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.sym_strobe) begin
                exp_t e;
                e = sbq.pop_front();
                chk("sym_bit", 64'(bus.data_mod), 64'(e.bit_v));
                chk("sym_count", 64'(bus.sym_count), 64'(e.cnt));
                chk("strobe_cycle", 64'(cyc), 64'(e.at));
            end
        end
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: left=%0d expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Drop en at a negedge and check the abort outputs after the next edge
    task automatic stop_run();
        bus.en = 1'b0;
        @(negedge clk);
        chk("stop_data", 64'(bus.data_mod), 64'd0);
        chk("stop_busy", 64'(bus.busy), 64'd0);
        chk("stop_strobe", 64'(bus.sym_strobe), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int   s;
        int   got;
        int   n;
        int   ones;
        int   diffs;
        logic prbs[1022];
        logic [15:0] held_cnt;

        vecs[0] = mk(2'd2, 31, 0, 32'h0000_0000, 9'h1FF, 6, 16'h0020);
        vecs[1] = mk(2'd3, 3, 4, 32'h0000_000D, 9'h1FF, 10, 16'h00D5);
        vecs[2] = mk(2'd1, 0, 0, 32'h0000_0000, 9'h1FF, 8, 16'h0055);
        vecs[3] = mk(2'd0, 2, 3, 32'hFFFF_FFFF, 9'h1FF, 7, 16'h0005);
        vecs[4] = mk(2'd2, 1, 0, 32'h0000_0000, 9'h000, 10, 16'h01E0);
        vecs[5] = mk(2'd3, 1, 0, 32'hA5A5_0003, 9'h1FF, 8, 16'h0003);
        vecs[6] = mk(2'd1, 4, 3, 32'h0000_0000, 9'h1FF, 6, 16'h0015);

        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 2'd0; bus.sym_period = 16'd0; bus.pre_len = 8'd0;
        bus.pattern = 32'd0; bus.seed = 9'd0;
        bus4.en = 1'b0; bus4.mode = 2'd0; bus4.sym_period = 16'd0; bus4.pre_len = 8'd0;
        bus4.pattern = 32'd0; bus4.seed = 9'd0;
        #1;
        chk("rst_data", 64'(bus.data_mod), 64'd0);
        chk("rst_strobe", 64'(bus.sym_strobe), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_count", 64'(bus.sym_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_data", 64'(bus.data_mod), 64'd0);

        for (int i = 0; i < 7; i++) begin
            start_run(vecs[i], 1'b1, s);
            drain(vecs[i].nbits * (vecs[i].sp + 1) + 8);
            stop_run();
        end

        // Abort mid-symbol, then restart from the seed
        start_run(mk(2'd2, 31, 0, 32'd0, 9'h1FF, 1, 16'h0000), 1'b1, s);
        drain(40);
        while (cyc < s + 49) @(negedge clk);
        chk("abort_busy_before", 64'(bus.busy), 64'd1);
        held_cnt = bus.sym_count;
        bus.en = 1'b0;
        @(negedge clk);
        chk("abort_data", 64'(bus.data_mod), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_strobe", 64'(bus.sym_strobe), 64'd0);
        chk("abort_count_held", 64'(bus.sym_count), 64'd1);
        chk("abort_count_stable", 64'(bus.sym_count), 64'(held_cnt));
        start_run(mk(2'd2, 31, 0, 32'd0, 9'h1FF, 6, 16'h0020), 1'b1, s);
        drain(6 * 32 + 8);
        stop_run();

        // Asynchronous reset between edges while running, then restart with en held
        start_run(mk(2'd1, 7, 0, 32'd0, 9'h1FF, 3, 16'h0005), 1'b1, s);
        drain(40);
        chk("pre_reset_data", 64'(bus.data_mod), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", 64'(bus.data_mod), 64'd0);
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_count", 64'(bus.sym_count), 64'd0);
        chk("async_rst_strobe", 64'(bus.sym_strobe), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(mk(2'd1, 7, 0, 32'd0, 9'h1FF, 4, 16'h0005), 1'b0, s);
        drain(50);
        stop_run();

        // PRBS9 period and balance at one symbol per cycle
        bus.mode = 2'd2; bus.sym_period = 16'd0; bus.pre_len = 8'd0; bus.seed = 9'h1FF;
        bus.en = 1'b1;
        got = 0; n = 0;
        while (got < 1022 && n < 1100) begin
            @(negedge clk);
            n++;
            if (bus.sym_strobe) begin
                prbs[got] = bus.data_mod;
                got++;
            end
        end
        chk("prbs_collected", 64'(got), 64'd1022);
        ones = 0; diffs = 0;
        for (int i = 0; i < 511; i++) begin
            if (prbs[i] === 1'b1) ones++;
            if (prbs[i] !== prbs[i + 511]) diffs++;
        end
        chk("prbs_ones", 64'(ones), 64'd256);
        chk("prbs_period", 64'(diffs), 64'd0);
        stop_run();

        // Narrow counter saturation on the second instance
        bus4.mode = 2'd0; bus4.sym_period = 16'd0; bus4.pre_len = 8'd0; bus4.seed = 9'h1FF;
        bus4.en = 1'b1;
        repeat (15) @(negedge clk);
        chk("sat_count_14", 64'(bus4.sym_count), 64'd14);
        @(negedge clk);
        chk("sat_count_15", 64'(bus4.sym_count), 64'd15);
        repeat (10) @(negedge clk);
        chk("sat_count_hold", 64'(bus4.sym_count), 64'd15);
        chk("sat_strobe", 64'(bus4.sym_strobe), 64'd1);
        bus4.en = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
